uart_tx: RTL and testbench

Byte-wide UART transmitter that drives the board's TXD pin, which is currently tied low. It accepts one byte per valid/ready handshake and serialises it as 8N1 (optionally 8E1): LSB first, one start bit, one stop bit. It sits in the top-level next to the LED logic and shares the system clock `CLK`. Later examples use it to report counter values and received characters over the E1 USB-UART bridge.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int E1_CLK_HZ        = 10_000_000;
  localparam int UART_CLKS_115200 = 87;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

  function automatic logic even_parity(
    input logic [UART_DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake between a producer and the transmitter.
// master = producer, slave = transmitter.
interface uart_tx_if;

  logic [uart_pkg::UART_DATA_W-1:0] tx_data;
  logic                             tx_valid;
  logic                             tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Per-bit clock counter; bit_end marks the last cycle of a bit.
// Shared with a future receiver, so it knows nothing about frames.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = en && (count == LAST);

  // Count 0..LAST while enabled, wrap at bit end.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (bit_end) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte UART transmitter, 8N1/8N2, or 8E1/8E2 when
// UART_TX_PARITY_EN is defined. TXD is always a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_115200,
  parameter int STOP_BITS    = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  uart_tx_if.slave     tx,
  output logic         busy,
  output logic         TXD
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_tx_state_t         state, state_next;
  logic [UART_DATA_W-1:0] shift, shift_next;
  logic [2:0]             idx, idx_next;
  logic                   txd_next;
  logic                   accept;
  logic                   bit_end;
  logic                   clear;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`endif

  assign tx.tx_ready = (state == IDLE) && !RESET;
  assign busy        = (state != IDLE);
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign clear       = (state_next != state);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (clear),
    .en     (busy),
    .bit_end(bit_end)
  );

  // Next state, next datapath values and next line level.
  always_comb begin
    state_next = state;
    shift_next = shift;
    idx_next   = idx;
    txd_next   = 1'b1;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shift_next = tx.tx_data;
          idx_next   = '0;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        txd_next = shift[0];
        if (bit_end) begin
          shift_next = {1'b0, shift[UART_DATA_W-1:1]};
          if (idx == 3'd7) begin
            idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_next = parity_q;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        txd_next = 1'b1;
        // idx counts stop bits here.
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shift register, bit index and TXD registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      TXD   <= 1'b1;
    end else begin
      state <= state_next;
      shift <= shift_next;
      idx   <= idx_next;
      TXD   <= txd_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at accept since the shifter is destroyed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= even_parity(tx.tx_data);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps plus random
// bytes, checked against a frame-level bit list model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C  = 4;
  localparam int S  = 1;
  localparam int C2 = 2;
  localparam int S2 = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  always #5 CLK = ~CLK;

  uart_tx_if a_if ();
  uart_tx_if b_if ();

  logic a_busy, a_txd;
  logic b_busy, b_txd;

  uart_tx #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (S)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .tx   (a_if.slave),
    .busy (a_busy),
    .TXD  (a_txd)
  );

  uart_tx #(
    .CLKS_PER_BIT(C2),
    .STOP_BITS   (S2)
  ) dut2 (
    .CLK  (CLK),
    .RESET(RESET),
    .tx   (b_if.slave),
    .busy (b_busy),
    .TXD  (b_txd)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Frame as a list of line levels, one per bit time.
  function automatic int frame_bits(
    input  logic [7:0] b,
    input  int         stops,
    output bit         bits[16]
  );
    int n;
    for (int i = 0; i < 16; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    bits[n] = ^b;
    n++;
`endif
    for (int i = 0; i < stops; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // Send one byte on the C=4 instance and check every cycle.
  task automatic send_a(
    input  logic [7:0] b,
    input  bit         hold,
    input  logic [7:0] nxt,
    input  bit         noise,
    output int         acc_cyc,
    output int         len
  );
    bit bits[16];
    int n;
    a_if.tx_data  = b;
    a_if.tx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (a_if.tx_ready) break;
      step();
    end
    check("ready_wait", 32'(a_if.tx_ready), 32'd1);
    step();
    acc_cyc = cyc;
    check("acc_txd", 32'(a_txd), 32'd1);
    check("acc_busy", 32'(a_busy), 32'd1);
    check("acc_ready", 32'(a_if.tx_ready), 32'd0);
    a_if.tx_valid = 1'b0;
    if (noise) a_if.tx_data = ~b;
    n   = frame_bits(b, S, bits);
    len = n * C;
    for (int t = 0; t < len; t++) begin
      step();
      check("txd", 32'(a_txd), 32'(bits[t/C]));
      check("busy", 32'(a_busy), 32'(t < len - 1));
      check("ready", 32'(a_if.tx_ready), 32'(t == len - 1));
      if (noise && t < len - 1) begin
        a_if.tx_data  = 8'($urandom);
        a_if.tx_valid = 1'($urandom_range(0, 1));
      end
    end
    a_if.tx_valid = hold;
    a_if.tx_data  = nxt;
  endtask

  int  acc1, acc2, len1, len2, n2;
  bit  bits2[16];
  logic [7:0] cur, nxt;
  bit  hold, prev_hold;
  int  prev_acc, prev_len;

  initial begin
    a_if.tx_data  = '0;
    a_if.tx_valid = 1'b0;
    b_if.tx_data  = '0;
    b_if.tx_valid = 1'b0;
    RESET = 1'b1;
    step();
    step();
    check("rst_txd", 32'(a_txd), 32'd1);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_ready", 32'(a_if.tx_ready), 32'd0);
    check("rst_ready2", 32'(b_if.tx_ready), 32'd0);
    RESET = 1'b0;
    step();
    check("rel_ready", 32'(a_if.tx_ready), 32'd1);
    check("rel_txd", 32'(a_txd), 32'd1);

    send_a(8'h55, 1'b0, 8'h00, 1'b0, acc1, len1);

    send_a(8'hA3, 1'b1, 8'h0F, 1'b0, acc1, len1);
    send_a(8'h0F, 1'b0, 8'h00, 1'b0, acc2, len2);
    check("b2b_gap", 32'(acc2 - acc1), 32'(len1 + 1));

    send_a(8'h07, 1'b0, 8'h00, 1'b0, acc1, len1);
    send_a(8'h03, 1'b0, 8'h00, 1'b0, acc1, len1);

    a_if.tx_data  = 8'hFF;
    a_if.tx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (a_if.tx_ready) break;
      step();
    end
    step();
    a_if.tx_valid = 1'b0;
    for (int k = 0; k < 4 * C + 2; k++) step();
    check("mid_bit3", 32'(a_txd), 32'd1);
    check("mid_busy", 32'(a_busy), 32'd1);
    RESET = 1'b1;
    step();
    check("mr_txd", 32'(a_txd), 32'd1);
    check("mr_busy", 32'(a_busy), 32'd0);
    check("mr_ready", 32'(a_if.tx_ready), 32'd0);
    RESET = 1'b0;
    step();
    check("mr_rel_ready", 32'(a_if.tx_ready), 32'd1);
    send_a(8'h81, 1'b0, 8'h00, 1'b0, acc1, len1);

    send_a(8'h3C, 1'b0, 8'h00, 1'b1, acc1, len1);
    for (int k = 0; k < 3 * C; k++) begin
      step();
      check("one_frame_busy", 32'(a_busy), 32'd0);
      check("one_frame_txd", 32'(a_txd), 32'd1);
    end

    prev_hold = 1'b0;
    prev_acc  = 0;
    prev_len  = 0;
    cur = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      nxt  = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      send_a(cur, hold, nxt, 1'($urandom_range(0, 1)),
             acc1, len1);
      if (prev_hold)
        check("rnd_gap", 32'(acc1 - prev_acc),
              32'(prev_len + 1));
      prev_hold = hold;
      prev_acc  = acc1;
      prev_len  = len1;
      cur       = nxt;
    end
    a_if.tx_valid = 1'b0;
    for (int k = 0; k < 60; k++) step();

    b_if.tx_data  = 8'h00;
    b_if.tx_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (b_if.tx_ready) break;
      step();
    end
    check("b_ready_wait", 32'(b_if.tx_ready), 32'd1);
    step();
    b_if.tx_valid = 1'b0;
    check("b_acc_busy", 32'(b_busy), 32'd1);
    n2 = frame_bits(8'h00, S2, bits2);
    for (int t = 0; t < n2 * C2; t++) begin
      step();
      check("b_txd", 32'(b_txd), 32'(bits2[t/C2]));
      check("b_busy", 32'(b_busy), 32'(t < n2 * C2 - 1));
    end
    step();
    check("b_idle_txd", 32'(b_txd), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
